// File: rtl/playback_timer.sv
// Elapsed-playback M:SS timer with play/pause/stop control, track-end
// detection and a time/volume display select line.
//
// Parameters:
//   CLK_FREQ        - clock cycles per elapsed second (>= 2)
//   OVERLAY_SECONDS - seconds the volume overlay stays up (1..15)
// Ports:
//   clk, reset                        - clock, async active-high reset
//   play_pause, stop, volume_changed  - one-cycle control pulses
//   track_len_min/sec1/sec0           - BCD track length (0:00 = unlimited)
//   minutes0, seconds1, seconds0      - BCD elapsed time
//   running                           - time is advancing
//   track_end                         - one-cycle pulse at track length
//   select                            - 1 = show volume, 0 = show time
// Optional feature: define VOLUME_OVERLAY_EN to build the volume overlay
// timer; without it select is tied to 0 and volume_changed is unused.
module playback_timer #(
    parameter int CLK_FREQ        = 50000000,
    parameter int OVERLAY_SECONDS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_pause,
    input  logic       stop,
    input  logic       volume_changed,
    input  logic [3:0] track_len_min,
    input  logic [3:0] track_len_sec1,
    input  logic [3:0] track_len_sec0,
    output logic [3:0] minutes0,
    output logic [3:0] seconds1,
    output logic [3:0] seconds0,
    output logic       running,
    output logic       track_end,
    output logic       select
);

    localparam int            PW      = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_FREQ - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [3:0]    nxt_min;
    logic [3:0]    nxt_s1;
    logic [3:0]    nxt_s0;
    logic          len_ok;
    logic          hit_len;
    logic          at_len;

    assign tick = running && (prescaler == PRE_TOP);

    // BCD increment with 9:59 -> 0:00 wrap
    always_comb begin
        nxt_s0  = seconds0 + 4'd1;
        nxt_s1  = seconds1;
        nxt_min = minutes0;
        if (seconds0 == 4'd9) begin
            nxt_s0 = 4'd0;
            nxt_s1 = seconds1 + 4'd1;
            if (seconds1 == 4'd5) begin
                nxt_s1  = 4'd0;
                nxt_min = (minutes0 == 4'd9) ? 4'd0 : minutes0 + 4'd1;
            end
        end
    end

    // A zero or non-BCD length disables track-end matching entirely
    always_comb begin
        len_ok = (track_len_min <= 4'd9) && (track_len_sec1 <= 4'd5) &&
                 (track_len_sec0 <= 4'd9) &&
                 ({track_len_min, track_len_sec1, track_len_sec0} != 12'd0);
        hit_len = len_ok &&
                  ({nxt_min, nxt_s1, nxt_s0} ==
                   {track_len_min, track_len_sec1, track_len_sec0});
        at_len  = len_ok &&
                  ({minutes0, seconds1, seconds0} ==
                   {track_len_min, track_len_sec1, track_len_sec0});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            minutes0  <= 4'd0;
            seconds1  <= 4'd0;
            seconds0  <= 4'd0;
            running   <= 1'b0;
            track_end <= 1'b0;
        end else begin
            track_end <= 1'b0;
            if (stop) begin
                prescaler <= '0;
                minutes0  <= 4'd0;
                seconds1  <= 4'd0;
                seconds0  <= 4'd0;
                running   <= 1'b0;
            end else if (tick) begin
                prescaler <= '0;
                minutes0  <= nxt_min;
                seconds1  <= nxt_s1;
                seconds0  <= nxt_s0;
                if (hit_len) begin
                    running   <= 1'b0;
                    track_end <= 1'b1;
                end
            end else if (play_pause) begin
                if (running) begin
                    running <= 1'b0;
                end else begin
                    running <= 1'b1;
                    // Restarting a finished track begins again from 0:00
                    if (at_len) begin
                        prescaler <= '0;
                        minutes0  <= 4'd0;
                        seconds1  <= 4'd0;
                        seconds0  <= 4'd0;
                    end
                end
            end else if (running) begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

`ifdef VOLUME_OVERLAY_EN
    localparam logic [3:0] OV_LOAD = 4'(OVERLAY_SECONDS);

    logic [PW-1:0] ov_pre;
    logic [PW-1:0] ov_pre_nxt;
    logic [3:0]    ov_cnt;
    logic [3:0]    ov_cnt_nxt;

    // Overlay prescaler runs regardless of playback state
    always_comb begin
        ov_pre_nxt = (ov_pre == PRE_TOP) ? '0 : ov_pre + PW'(1);
        ov_cnt_nxt = ov_cnt;
        if (volume_changed) begin
            ov_pre_nxt = '0;
            ov_cnt_nxt = OV_LOAD;
        end else if ((ov_pre == PRE_TOP) && (ov_cnt != 4'd0)) begin
            ov_cnt_nxt = ov_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_pre <= '0;
            ov_cnt <= 4'd0;
            select <= 1'b0;
        end else begin
            ov_pre <= ov_pre_nxt;
            ov_cnt <= ov_cnt_nxt;
            select <= (ov_cnt_nxt != 4'd0);
        end
    end
`else
    logic unused_overlay;

    assign unused_overlay = volume_changed | (OVERLAY_SECONDS == 0);
    assign select         = 1'b0;
`endif

endmodule
